// File: rtl/psum_accq_pkg.sv
// Shared helpers for the partial-sum accumulator / requantizer.
// Optional macro PSUM_ACCQ_RELU_EN selects ReLU + unsigned clamp in the top.
package psum_accq_pkg;

  localparam int TILES_DEF = 4;
  localparam int ACC_W_DEF = 24;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int CNT_W     = (clog2(TILES_DEF) < 1) ? 1 : clog2(TILES_DEF);
  localparam int SHIFT_MAX = ACC_W_DEF - 1;

  // Clamp a signed value to an out_w-bit range: unsigned [0, 2^w-1] when
  // relu is set, otherwise two's complement [-2^(w-1), 2^(w-1)-1].
  function automatic logic [31:0] sat_clamp(input logic signed [63:0] value,
                                            input int out_w, input bit relu);
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    logic signed [63:0] v;
    if (relu) begin
      lo = '0;
      hi = (64'sd1 <<< out_w) - 64'sd1;
    end else begin
      lo = -(64'sd1 <<< (out_w - 1));
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    end
    if (value < lo)      v = lo;
    else if (value > hi) v = hi;
    else                 v = value;
    return v[31:0];
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Small synchronous FIFO with a registered head entry driving the output.
module psum_out_fifo
  import psum_accq_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = head_q;
  assign count   = count_q;

  // Pointer, occupancy and head-register next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
    if (empty) begin
      if (do_push) head_d = push_data;
    end else if (do_pop) begin
      if (count_q == CW'(1)) begin
        if (do_push) head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_q + AW'(1)];
      end
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/psum_accum_requant.sv
// Accumulates TILES signed partial sums, requantizes (round half up, arithmetic
// shift, clamp) and buffers results in an output FIFO; overflowing results are
// dropped and counted. Macro PSUM_ACCQ_RELU_EN selects ReLU/unsigned clamping.
module psum_accum_requant
  import psum_accq_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int TILES      = 4,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  input  logic [4:0]             cfg_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   ovf_sticky,
  output logic [7:0]             drop_cnt
);

  localparam int TC_W = (clog2(TILES) < 1) ? 1 : clog2(TILES);
  localparam int ACC1 = ACC_W + 1;
  localparam logic [TC_W-1:0] LAST_TILE = TC_W'(TILES - 1);
  localparam logic [4:0] SHIFT_CAP = (ACC_W - 1 > 31) ? 5'd31 : 5'(ACC_W - 1);
`ifdef PSUM_ACCQ_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  if (ACC_W < IN_W + clog2(TILES)) begin : g_chk_acc_w
    $fatal(1, "psum_accum_requant: ACC_W too small for IN_W and TILES");
  end
  if (TILES < 1 || TILES > 256) begin : g_chk_tiles
    $fatal(1, "psum_accum_requant: TILES must be 1..256");
  end
  if (FIFO_DEPTH < 2 || (1 << clog2(FIFO_DEPTH)) != FIFO_DEPTH) begin : g_chk_depth
    $fatal(1, "psum_accum_requant: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [TC_W-1:0]         tile_cnt_q, tile_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]              shift_lat_q, shift_lat_d;
  logic                    rq_valid_q, rq_valid_d;
  logic [OUT_W-1:0]        rq_data_q, rq_data_d;
  logic                    ovf_sticky_q, ovf_sticky_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;

  logic [4:0]              shift_cfg, shift_eff;
  logic                    first_tile, last_tile;
  logic signed [ACC_W:0]   in_ext, sum, rnd, rounded, q;
  logic signed [63:0]      q_wide;
  logic [OUT_W-1:0]        clamped;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  logic [clog2(FIFO_DEPTH):0] fifo_count;

  // Accumulate, requantize and drop accounting next-state.
  always_comb begin
    shift_cfg  = (cfg_shift > SHIFT_CAP) ? SHIFT_CAP : cfg_shift;
    first_tile = (tile_cnt_q == '0);
    last_tile  = (tile_cnt_q == LAST_TILE);
    // Tile 0 uses the live shift so TILES=1 samples cfg_shift per input.
    shift_eff  = first_tile ? shift_cfg : shift_lat_q;
    in_ext     = {{(ACC1 - IN_W){in_data[IN_W-1]}}, in_data};
    sum        = first_tile ? in_ext : ({acc_q[ACC_W-1], acc_q} + in_ext);
    rnd        = (shift_eff == 5'd0) ? '0 : (ACC1'(1) << (shift_eff - 5'd1));
    rounded    = sum + rnd;
    q          = rounded >>> shift_eff;
    q_wide     = {{(63 - ACC_W){q[ACC_W]}}, q};
    clamped    = OUT_W'(sat_clamp(q_wide, OUT_W, RELU_ON));

    tile_cnt_d  = tile_cnt_q;
    acc_d       = acc_q;
    shift_lat_d = shift_lat_q;
    if (in_valid) begin
      tile_cnt_d = last_tile ? '0 : tile_cnt_q + TC_W'(1);
      acc_d      = sum[ACC_W-1:0];
      if (first_tile) shift_lat_d = shift_cfg;
    end
    rq_valid_d = in_valid && last_tile;
    rq_data_d  = (in_valid && last_tile) ? clamped : rq_data_q;

    fifo_pop     = out_valid && out_ready;
    drop         = rq_valid_q && fifo_full && !fifo_pop;
    fifo_push    = rq_valid_q && !drop;
    ovf_sticky_d = ovf_sticky_q | drop;
    drop_cnt_d   = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // Pipeline and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_cnt_q   <= '0;
      acc_q        <= '0;
      shift_lat_q  <= '0;
      rq_valid_q   <= 1'b0;
      rq_data_q    <= '0;
      ovf_sticky_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      tile_cnt_q   <= tile_cnt_d;
      acc_q        <= acc_d;
      shift_lat_q  <= shift_lat_d;
      rq_valid_q   <= rq_valid_d;
      rq_data_q    <= rq_data_d;
      ovf_sticky_q <= ovf_sticky_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  psum_out_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rq_data_q),
    .pop       (fifo_pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign ovf_sticky = ovf_sticky_q;
  assign drop_cnt   = drop_cnt_q;

  // Occupancy and empty flag must always agree.
  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_empty == (fifo_count == '0));
  end

endmodule

// File: tb/tb_psum_accum_requant.sv
// Directed self-checking bench for psum_accum_requant (TILES=4, cfg_shift=2).
module tb_psum_accum_requant;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [4:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        ovf_sticky;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PSUM_ACCQ_RELU_EN
  localparam logic [3:0] EXP_BASIC = 4'd8;
  localparam logic [3:0] EXP_NEG   = 4'd0;
  localparam logic [3:0] EXP_SAT   = 4'd15;
`else
  localparam logic [3:0] EXP_BASIC = 4'd7;
  localparam logic [3:0] EXP_NEG   = 4'h8;
  localparam logic [3:0] EXP_SAT   = 4'd7;
`endif

  psum_accum_requant dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cfg_shift  (cfg_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ovf_sticky (ovf_sticky),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_in(input int x);
    in_valid = 1'b1;
    in_data  = 16'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d);
    push_in(a);
    push_in(b);
    push_in(c);
    push_in(d);
  endtask

  // Sends one group with out_ready=1, samples the output at t+2, then pops.
  task automatic run_single(input int a, input int b, input int c, input int d,
                            output logic v, output logic [3:0] dat);
    out_ready = 1'b1;
    send_group(a, b, c, d);
    @(posedge clk);
    #1;
    v   = out_valid;
    dat = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_shift = 5'd2; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_data !== 4'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_tests++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_sticky); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_ready_no_pop got %b want 0", out_valid); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_group(10, 20, -5, 7);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_t1_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_t2_valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== EXP_BASIC) begin n_fail++; $display("FAIL basic_data got %0d want %0d", out_data, EXP_BASIC); end
    @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got %b want 0", out_valid); end
    $display("[TB] basic group 10,20,-5,7 -> %0d", out_data);
  endtask

  task automatic test_rounding;
    logic v;
    logic [3:0] dat;
    run_single(6, 0, 0, 0, v, dat);
    n_tests++; if (v !== 1'b1 || dat !== 4'd2) begin n_fail++; $display("FAIL round_6 got v=%b d=%0d want v=1 d=2", v, dat); end
    $display("[TB] group 6,0,0,0 -> %0d", dat);
    run_single(-100, 0, 0, 0, v, dat);
    n_tests++; if (v !== 1'b1 || dat !== EXP_NEG) begin n_fail++; $display("FAIL round_neg got v=%b d=%0d want v=1 d=%0d", v, dat, EXP_NEG); end
    $display("[TB] group -100,0,0,0 -> %0d", dat);
  endtask

  task automatic test_saturation;
    logic v;
    logic [3:0] dat;
    run_single(32767, 32767, 32767, 32767, v, dat);
    n_tests++; if (v !== 1'b1 || dat !== EXP_SAT) begin n_fail++; $display("FAIL saturate got v=%b d=%0d want v=1 d=%0d", v, dat, EXP_SAT); end
    $display("[TB] group 4x32767 -> %0d", dat);
  endtask

  task automatic test_backpressure;
    int pops;
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) send_group(4, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== 4'd1) begin n_fail++; $display("FAIL bp_head got %0d want 1", out_data); end
    n_tests++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b want 1", ovf_sticky); end
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_drop_cnt got %0d want 1", drop_cnt); end
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        n_tests++; if (out_data !== 4'd1) begin n_fail++; $display("FAIL bp_pop_data got %0d want 1", out_data); end
        pops++;
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (pops != 4) begin n_fail++; $display("FAIL bp_pop_count got %0d want 4", pops); end
    $display("[TB] backpressure popped %0d entries, drop_cnt=%0d", pops, drop_cnt);
  endtask

  task automatic test_full_pop;
    logic [3:0] exp_seq [4];
    int idx;
    exp_seq = '{4'd2, 4'd3, 4'd4, 4'd5};
    out_ready = 1'b0;
    send_group(4, 0, 0, 0);
    send_group(8, 0, 0, 0);
    send_group(12, 0, 0, 0);
    send_group(16, 0, 0, 0);
    send_group(20, 0, 0, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL fullpop_drop_cnt got %0d want 1", drop_cnt); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== 4'd2) begin n_fail++; $display("FAIL fullpop_head got v=%b d=%0d want v=1 d=2", out_valid, out_data); end
    out_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        if (idx < 4) begin
          n_tests++; if (out_data !== exp_seq[idx]) begin n_fail++; $display("FAIL fullpop_order[%0d] got %0d want %0d", idx, out_data, exp_seq[idx]); end
        end
        idx++;
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (idx != 4) begin n_fail++; $display("FAIL fullpop_count got %0d want 4", idx); end
    $display("[TB] full+pop drained %0d entries", idx);
  endtask

  task automatic test_reset_mid;
    int outs;
    logic [3:0] first;
    out_ready = 1'b1;
    push_in(100);
    push_in(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (ovf_sticky !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_status got ovf=%b drop=%0d want 0 0", ovf_sticky, drop_cnt); end
    send_group(4, 4, 4, 4);
    outs = 0;
    first = 4'hx;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        if (outs == 0) first = out_data;
        outs++;
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (outs != 1) begin n_fail++; $display("FAIL midrst_out_count got %0d want 1", outs); end
    n_tests++; if (first !== 4'd4) begin n_fail++; $display("FAIL midrst_data got %0d want 4", first); end
    $display("[TB] reset mid-group -> %0d outputs, first=%0d", outs, first);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accum_requant.md
Name: psum_accum_requant

Overview:
- Downstream consumer of the spike_array dot-product stage.
- Takes one signed 16-bit partial sum per `done` pulse and accumulates TILES consecutive partial sums, so a K=TILES*128 dot product is built from 128-wide slices.
- Requantizes the total (round, shift, clamp) to an OUT_W-bit activation for the next layer.
- Results are buffered in a small FIFO with valid/ready output, because spike_array cannot be stalled.

Parameters:
- IN_W, 16, width of incoming signed partial sum (spike_array result)
- TILES, 4, partial sums per output; range 1..256
- ACC_W, 24, accumulator width; must be >= IN_W + clog2(TILES)
- OUT_W, 4, output activation width
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2

Ports:
- clk, in, 1, clock; all logic on posedge
- rst, in, 1, synchronous active-high reset
- in_valid, in, 1, partial-sum strobe; driven by spike_array done
- in_data, in, IN_W, signed partial sum
- cfg_shift, in, 5, right-shift amount; values > ACC_W-1 are treated as ACC_W-1
- out_valid, out, 1, FIFO non-empty
- out_ready, in, 1, consumer accepts head entry
- out_data, out, OUT_W, requantized activation at FIFO head
- ovf_sticky, out, 1, set when a result was dropped because the FIFO was full
- drop_cnt, out, 8, saturating count of dropped results

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - tile_cnt=0, acc=0, rq_valid=0, FIFO empty, out_valid=0, out_data=0, ovf_sticky=0, drop_cnt=0.
  - Reset mid-group discards the partial accumulation; the next in_valid starts a new group at tile 0.
- Accumulate stage (on in_valid=1), with in_data sign-extended to ACC_W:
  - tile_cnt==0: acc <= sext(in_data); shift_lat <= clamped cfg_shift.
  - otherwise: acc <= acc + sext(in_data).
  - tile_cnt increments and wraps to 0 after TILES-1.
  - TILES=1: every input is a complete group.
  - in_valid may be high every cycle; there are no bubbles and no input backpressure.
- Group completion, when in_valid=1 and tile_cnt==TILES-1:
  - sum = acc + sext(in_data), or sext(in_data) alone when TILES=1.
  - Round half up: r = sum + (shift_lat>0 ? 1<<(shift_lat-1) : 0), computed at ACC_W+1 bits.
  - q = r >>> shift_lat (arithmetic).
  - Clamp q per the Optional Feature.
  - Result is registered into rq_data with rq_valid=1 at the end of that cycle.
  - cfg_shift is sampled only at tile 0 (or per input when TILES=1).
- FIFO push and pop:
  - rq_valid pushes into the FIFO on the next edge.
  - Latency: last-tile in_valid in cycle t gives out_valid=1 in cycle t+2 when the FIFO was empty.
- Output handshake:
  - Pop occurs when out_valid && out_ready.
  - out_data is the head entry; it is stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - FIFO full, push, and pop in the same cycle: both occur and count is unchanged.
  - FIFO full, push, no pop: the result is dropped, ovf_sticky <= 1, drop_cnt increments and saturates at 255.
  - FIFO empty with out_ready=1: no pop; out_valid=0.
  - ovf_sticky and drop_cnt clear only on rst.
- Accumulator overflow cannot occur when the ACC_W constraint holds; the parameter check is elaborated as a fatal assertion.

Optional Feature:
- Macro: PSUM_ACCQ_RELU_EN.
- Defined: ReLU plus unsigned clamp; q<0 -> 0, q>2^OUT_W-1 -> 2^OUT_W-1; out_data is unsigned.
- Undefined: signed saturation to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_data is two's complement.

Decomposition:
- Package psum_accq_pkg holds:
  - the function clog2;
  - the function sat_clamp(value, relu flag);
  - localparams CNT_W=clog2(TILES) and SHIFT_MAX=ACC_W-1.
- One sub-module, psum_out_fifo: a synchronous FIFO with push/pop/full/empty/count and a registered head.
  - Accumulator, requant stage and drop logic stay in the top module.

Test Plan:
All cases use TILES=4, cfg_shift=2, RELU_EN defined unless noted.
1. Inputs 10,20,-5,7 back-to-back, out_ready=1 -> out_data=8, since (32+2)>>2=8; out_valid is high exactly in cycle t+2 after the 4th input.
2. Rounding and negatives:
   - Inputs 6,0,0,0 -> 2.
   - Inputs -100,0,0,0 -> 0 (ReLU).
   - Without PSUM_ACCQ_RELU_EN, inputs -100,0,0,0 -> -8 (4'h8).
3. Saturation: four inputs of 32767 -> 15 with RELU_EN defined, 7 without.
4. Backpressure: out_ready=0, 5 complete groups each summing to 4 ->
   - 4 entries of value 1 held in the FIFO;
   - 5th group dropped; ovf_sticky=1, drop_cnt=1;
   - raising out_ready then pops exactly 4 entries.
5. Full with simultaneous pop: FIFO full, out_ready=1 in the cycle a new result pushes -> no drop, count stays 4, output order preserved.
6. Reset mid-group: inputs 100,100, then rst for 1 cycle, then inputs 4,4,4,4 -> single output 4; no residue from the pre-reset inputs.
